// File: rtl/itype_exec_sequencer_pkg.sv
// itype_exec_sequencer_pkg: shared opcode, state encoding, func3 values and field accessors
package itype_exec_sequencer_pkg;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int IMM_LSB = 20;
    localparam int F7_LSB  = 25;

    function automatic logic [6:0] f_opcode(input logic [31:0] i);
        return i[OPC_LSB +: 7];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[RD_LSB +: 5];
    endfunction

    function automatic logic [2:0] f_func3(input logic [31:0] i);
        return i[F3_LSB +: 3];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] i);
        return i[RS1_LSB +: 5];
    endfunction

    function automatic logic [11:0] f_imm(input logic [31:0] i);
        return i[IMM_LSB +: 12];
    endfunction

    function automatic logic [6:0] f_funct7(input logic [31:0] i);
        return i[F7_LSB +: 7];
    endfunction

endpackage

// File: rtl/itype_exec_sequencer_legal_check.sv
// itype_legal_check: flags non-OP-IMM opcodes and malformed shift-immediate encodings
module itype_legal_check
    import itype_exec_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic        illegal
);

    logic [2:0] func3;
    logic [6:0] funct7;
    logic       bad_opc;
    logic       bad_sll;
    logic       bad_sr;

    assign func3   = f_func3(instr);
    assign funct7  = f_funct7(instr);
    assign bad_opc = f_opcode(instr) != OPC_OPIMM;
    assign bad_sll = func3 == F3_SLLI && funct7 != F7_ZERO;
    assign bad_sr  = func3 == F3_SRXI && funct7 != F7_ZERO && funct7 != F7_SRA;
    assign illegal = bad_opc || bad_sll || bad_sr;

endmodule

// File: rtl/itype_exec_sequencer.sv
// itype_exec_sequencer: four-state controller running one OP-IMM instruction through reg_file and ALU
module itype_exec_sequencer
    import itype_exec_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic [31:0]      alu_a,
    output logic [11:0]      alu_imm,
    output logic [2:0]       alu_func3,
    output logic [6:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       instr_q;
    logic [31:0]       opnd_q;
    logic [31:0]       res_q;
    logic              ill_q;
    logic              ill_w;
    logic [CNT_W-1:0]  retired_q;
    logic              accept;

    itype_legal_check u_legal (
        .instr   (instr),
        .illegal (ill_w)
    );

    assign accept = state_q == IDLE && instr_valid;

    // next-state: illegal instructions skip straight to the write-back slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = instr_valid ? (ill_w ? WB : READ) : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    // state register and datapath latches; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            opnd_q    <= '0;
            res_q     <= '0;
            ill_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= instr;
                ill_q   <= ill_w;
            end
            if (state_q == READ) opnd_q <= rf_rdata;
            if (state_q == EXEC) res_q <= alu_result;
            if (state_q == WB && !ill_q) retired_q <= retired_q + 1'b1;
        end
    end

    assign instr_ready = state_q == IDLE;
    assign rf_raddr    = f_rs1(instr_q);
    assign alu_a       = opnd_q;
    assign alu_imm     = f_imm(instr_q);
    assign alu_func3   = f_func3(instr_q);
    assign alu_opcode  = f_opcode(instr_q);
    assign done        = state_q == WB;
    assign illegal     = done && ill_q;
    assign rf_we       = done && !ill_q && f_rd(instr_q) != 5'd0;
    assign rf_waddr    = f_rd(instr_q);
    assign rf_wdata    = res_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_itype_exec_sequencer.sv
// tb_itype_exec_sequencer: directed stimulus with a cycle-countdown reference model and literal spot checks
module tb_itype_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] alu_a;
    logic [11:0] alu_imm;
    logic [2:0]  alu_func3;
    logic [6:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        illegal;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] rf [32];

    itype_exec_sequencer #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .alu_a       (alu_a),
        .alu_imm     (alu_imm),
        .alu_func3   (alu_func3),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .done        (done),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [11:0] imm, input logic [2:0] f3);
        logic [31:0] sx;
        sx = {{20{imm[11]}}, imm};
        case (f3)
            3'd0: return a + sx;
            3'd1: return a << imm[4:0];
            3'd2: return {31'd0, $signed(a) < $signed(sx)};
            3'd3: return {31'd0, a < sx};
            3'd4: return a ^ sx;
            3'd5: return imm[10] ? 32'($signed(a) >>> imm[4:0]) : a >> imm[4:0];
            3'd6: return a | sx;
            default: return a & sx;
        endcase
    endfunction

    function automatic logic legal_f(input logic [31:0] i);
        if (i[6:0] != 7'b0010011) return 1'b0;
        if (i[14:12] == 3'b001) return i[31:25] == 7'd0;
        if (i[14:12] == 3'b101) return i[31:25] == 7'd0 || i[31:25] == 7'b0100000;
        return 1'b1;
    endfunction

    assign rf_rdata   = rf[rf_raddr];
    assign alu_result = alu_f(alu_a, alu_imm, alu_func3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference model: an accepted instruction occupies 3 cycles (legal) or 1 (illegal); the last is write-back
    int          m_cnt = 0;
    logic        m_ill = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_opnd = '0;
    logic [31:0] m_res = '0;
    logic [31:0] m_ret = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_ret <= '0;
        end else if (m_cnt == 0) begin
            if (instr_valid) begin
                m_instr <= instr;
                m_ill   <= !legal_f(instr);
                m_opnd  <= rf[instr[19:15]];
                m_res   <= alu_f(rf[instr[19:15]], instr[31:20], instr[14:12]);
                m_cnt   <= legal_f(instr) ? 3 : 1;
            end
        end else begin
            if (m_cnt == 1 && !m_ill) m_ret <= m_ret + 1;
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", {31'd0, instr_ready}, {31'd0, m_cnt == 0});
            chk("done", {31'd0, done}, {31'd0, m_cnt == 1});
            chk("illegal", {31'd0, illegal}, {31'd0, m_cnt == 1 && m_ill});
            chk("we", {31'd0, rf_we}, {31'd0, m_cnt == 1 && !m_ill && m_instr[11:7] != 5'd0});
            chk("retired", retired, m_ret);
            if (m_cnt == 1 && !m_ill) begin
                chk("waddr", {27'd0, rf_waddr}, {27'd0, m_instr[11:7]});
                chk("wdata", rf_wdata, m_res);
            end
            if (m_cnt == 3) chk("raddr", {27'd0, rf_raddr}, {27'd0, m_instr[19:15]});
            if (m_cnt == 2) begin
                chk("alu_a", alu_a, m_opnd);
                chk("alu_imm", {20'd0, alu_imm}, {20'd0, m_instr[31:20]});
                chk("alu_func3", {29'd0, alu_func3}, {29'd0, m_instr[14:12]});
                chk("alu_opcode", {25'd0, alu_opcode}, {25'd0, m_instr[6:0]});
            end
        end
    end

    // offer word w (valid stays high); returns the cycle index after the accept edge
    task automatic offer(input logic [31:0] w, output int acc);
        acc = -1;
        instr_valid = 1'b1;
        instr = w;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            if (instr_ready) acc = cyc + 1;
            @(posedge clk);
            #2;
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int a0, a1, a2, a3;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 * i + i;
        rf[0] = 32'd0;
        rf[1] = 32'd10;
        #3;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        #9 rst_n = 1'b1;
        step(1);

        // ADDI x5,x1,-3
        offer(32'hFFD08293, a0);
        instr_valid = 1'b0;
        chk("t1_raddr", {27'd0, rf_raddr}, 32'd1);
        chk("t1_we_read", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t1_alu_a", alu_a, 32'd10);
        chk("t1_we_exec", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("t1_wdata", rf_wdata, 32'd7);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_illegal", {31'd0, illegal}, 32'd0);
        step(1);
        chk("t1_retired", retired, 32'd1);
        chk("t1_ready", {31'd0, instr_ready}, 32'd1);

        // ADDI x0,x2,5
        offer(32'h00510013, a0);
        instr_valid = 1'b0;
        step(2);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_we", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t2_retired", retired, 32'd2);

        // R-type add x1,x2,x3
        offer(32'h003100B3, a0);
        instr_valid = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_illegal", {31'd0, illegal}, 32'd1);
        chk("t3_we", {31'd0, rf_we}, 32'd0);
        step(1);
        chk("t3_ready", {31'd0, instr_ready}, 32'd1);
        chk("t3_retired", retired, 32'd2);

        // SLLI with funct7=0100000 is illegal
        offer(32'h40209193, a0);
        instr_valid = 1'b0;
        chk("t4_slli_illegal", {31'd0, illegal}, 32'd1);
        step(1);
        // SRAI x4,x1,2 is legal
        offer(32'h4020D213, a0);
        instr_valid = 1'b0;
        step(1);
        chk("t4_srai_imm", {20'd0, alu_imm}, 32'h402);
        step(1);
        chk("t4_srai_illegal", {31'd0, illegal}, 32'd0);
        chk("t4_srai_wdata", rf_wdata, 32'd2);
        step(1);
        chk("t4_retired", retired, 32'd3);

        // three back-to-back with valid held high
        offer(32'h00308313, a1);
        offer(32'h0011C393, a2);
        offer(32'hFFF1F413, a3);
        instr_valid = 1'b0;
        chk("t5_gap1", a2 - a1, 32'd4);
        chk("t5_gap2", a3 - a2, 32'd4);
        step(4);
        chk("t5_retired", retired, 32'd6);

        // reset during EXEC
        offer(32'h00108313, a0);
        instr_valid = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t6_ready", {31'd0, instr_ready}, 32'd1);
        chk("t6_we", {31'd0, rf_we}, 32'd0);
        chk("t6_retired", retired, 32'd0);
        chk("t6_alu_a", alu_a, 32'd0);
        #1 rst_n = 1'b1;
        step(1);
        offer(32'h00508393, a0);
        instr_valid = 1'b0;
        step(2);
        chk("t6_wdata", rf_wdata, 32'd15);
        step(1);
        chk("t6_retired_after", retired, 32'd1);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/itype_exec_sequencer.md
Name: itype_exec_sequencer

Overview:
Multi-cycle controller that sequences one RISC-V OP-IMM (I-type) instruction at a time through the register file and ALU datapath. It accepts an instruction over a valid/ready handshake and drives the register-file read address. It presents operands and control fields to the ALU, then commits the ALU result with a single write-enable pulse. It sits between the instruction source (fetch stub or testbench) and the reg_file/alu pair. It is the only agent driving their control pins.

Parameters:
CNT_W, 32, width of the retired-instruction counter
OPC_OPIMM, 7'b0010011, the only accepted opcode

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered this cycle
instr  input  32  instruction word
instr_ready  output  1  sequencer can accept an instruction
rf_raddr  output  5  register-file read address (rs1)
rf_rdata  input  32  register-file read data (combinational from rf_raddr)
alu_a  output  32  ALU operand A (latched rs1 value)
alu_imm  output  12  ALU immediate (instr[31:20])
alu_func3  output  3  ALU func3
alu_opcode  output  7  ALU opcode
alu_result  input  32  ALU result (combinational from alu_* inputs)
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  5  write address (rd)
rf_wdata  output  32  write data
done  output  1  one-cycle pulse: instruction retired or rejected
illegal  output  1  qualifies done: instruction was rejected
retired  output  CNT_W  count of legally retired instructions

Behaviour:
- Reset is asynchronous: rst_n low forces state IDLE, latched instr to 0 and operand/result latches to 0. It also clears rf_we, done, illegal and retired. instr_ready is 1 (IDLE). All datapath outputs are 0.
- Reset asserted mid-instruction aborts it. No rf_we is issued, and the counter is not advanced.
- States are IDLE, READ, EXEC, WB, and each runs as follows:
  - IDLE: instr_ready=1. When instr_valid=1, latch instr and go to READ. If the opcode is not OPC_OPIMM, the instruction is illegal and goes to WB with the illegal flag set instead.
  - Shift check in IDLE: func3=001 with instr[31:25]!=0 is illegal. func3=101 with instr[31:25] not 0000000 or 0100000 is illegal.
  - READ: drive rf_raddr=instr[19:15], latch rf_rdata into the operand register, go to EXEC.
  - EXEC: drive alu_a, alu_imm, alu_func3 and alu_opcode from the latches, latch alu_result, go to WB.
  - WB, legal instruction: rf_we=1, rf_waddr=instr[11:7], rf_wdata=latched result, done=1, retired+=1, go to IDLE.
  - WB, illegal instruction: rf_we=0, done=1, illegal=1, retired unchanged, go to IDLE.
- rd=x0: a legal instruction completes normally (done=1, retired+=1) but rf_we is forced 0.
- Outputs are stable: alu_* and rf_raddr hold their last driven values outside their active states. They change only on a new accept.
- Latency: accept edge to the WB cycle is 3 cycles. Throughput is 1 instruction per 4 cycles. instr_ready rises the cycle after WB.
- instr_valid while instr_ready=0 is ignored. instr is sampled only on the accept edge.
- retired wraps modulo 2^CNT_W.
- Illegal instructions take 1 accept cycle plus 1 WB cycle. done then follows 1 cycle after accept.

Decomposition:
- Shared package holds:
  - OPC_OPIMM
  - the state encoding (IDLE=2'd0, READ=2'd1, EXEC=2'd2, WB=2'd3)
  - func3 constants for ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI and SRLI/SRAI
  - instruction field bit-range constants
- One natural sub-module, itype_legal_check: combinational legality check of opcode/func3/funct7, output illegal. Everything else stays in the top FSM.

Test Plan:
1. ADDI x5,x1,-3 (0xFFD08293), rf_rdata=10 at rf_raddr=1, alu_result=7 → rf_we pulse exactly 3 cycles after accept with rf_waddr=5, rf_wdata=7; done=1, illegal=0, retired=1.
2. ADDI x0,x2,5 → done=1, rf_we stays 0 for the whole instruction, retired increments.
3. Opcode 0110011 (R-type) offered → done and illegal both pulse 1 cycle after accept; no rf_we; retired unchanged; instr_ready back to 1 the next cycle.
4. SLLI with instr[31:25]=0100000 → rejected as illegal. SRAI with 0100000 → legal, alu_imm=0x40X.
5. instr_valid held high with 3 back-to-back instructions → accepts exactly every 4 cycles; retired=3. Instructions offered while instr_ready=0 are not captured.
6. rst_n pulsed low during EXEC → immediate IDLE, instr_ready=1, no rf_we, retired=0. The next instruction completes normally.
